ucdp_sync_hs_ctrl: RTL and testbench

UCDP_SYNC_HS_CTRL -- requirements
Module: ucdp_sync_hs_ctrl

---
 rtl/ucdp_sync_hs_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ucdp_sync_hs_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucdp_sync_hs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ucdp_sync_hs_ctrl
// Description : 4-phase req/ack handshake controller toward an asynchronous
//               remote domain. The ack input is brought in through a 2-flop
//               synchronizer. A data word is captured on acceptance and held
//               on data_o while the handshake runs.
//               The optional handshake timeout is compiled in with the macro
//               UCDP_SYNC_HS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ucdp_sync_hs_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             busy_o,
  output logic             err_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd1;
  localparam logic [1:0] S_WAIT_LO = 2'd2;

  // Reject out-of-range configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("ucdp_sync_hs_ctrl: WIDTH must be within 1..64");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("ucdp_sync_hs_ctrl: TIMEOUT must be within 1..65535");
  end

  logic [1:0]       state_q, state_d;
  logic             ack_meta_q;
  logic             ack_s_q;
  logic             req_q, req_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;
  logic             timeout_fire;

  // Two-flop synchronizer: the raw ack is never observed by any other logic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack_i;
      ack_s_q    <= ack_meta_q;
    end
  end

`ifdef UCDP_SYNC_HS_TIMEOUT_EN
  // Fire when the current wait has lasted TIMEOUT cycles without progress.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        err_q;
  logic        timeout_hit;

  assign timeout_hit  = (state_q != S_IDLE) && (cnt_q == TO_LAST);
  // A timeout only matters when the expected ack level has not arrived yet.
  assign timeout_fire = timeout_hit &&
                        (((state_q == S_WAIT_HI) && !ack_s_q) ||
                         ((state_q == S_WAIT_LO) &&  ack_s_q));

  // Wait counter: cleared on every state entry, counts while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (state_q != S_IDLE) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter and one-cycle error pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 16'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_fire;
    end
  end

  assign err_o = err_q;
`else
  // Without the timeout feature the handshake waits indefinitely.
  assign timeout_fire = 1'b0;
  assign err_o        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a stale ack held high in IDLE blocks acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (ack_s_q || timeout_fire) begin
          state_d = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!ack_s_q || timeout_fire) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: handshake flags, acceptance and next values of output flops.
  always_comb begin
    ready_o = (state_q == S_IDLE) && !ack_s_q;
    busy_o  = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    accept  = ready_o && valid_i;
    // req is high exactly while the FSM waits for the rising ack.
    req_d   = (state_d == S_WAIT_HI);
    data_d  = accept ? data_i : data_q;
  end

  // Flop-driven request and captured data word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      data_q <= '0;
    end else begin
      req_q  <= req_d;
      data_q <= data_d;
    end
  end

  assign req_o  = req_q;
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_ucdp_sync_hs_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucdp_sync_hs_ctrl
// Description : Self-checking bench for ucdp_sync_hs_ctrl. A cycle model of
//               the handshake is compared against the DUT on every falling
//               edge; directed scenarios add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucdp_sync_hs_ctrl;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 10;
`ifdef UCDP_SYNC_HS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             req_o;
  logic [WIDTH-1:0] data_o;
  logic             ack_i;
  logic             busy_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

  ucdp_sync_hs_ctrl #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .req_o   (req_o),
    .data_o  (data_o),
    .ack_i   (ack_i),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_busy: a handshake is open; m_req: still waiting for ack to rise.
  // m_wait: whole cycles spent in the current waiting phase.
  bit               m_busy, m_req, m_err;
  logic [WIDTH-1:0] m_data;
  int               m_wait;
  bit   [1:0]       m_pipe;   // ack delayed by two clock edges
  bit               m_acks;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 0; m_req = 0; m_err = 0; m_data = '0; m_wait = 0; m_pipe = '0;
    end else begin
      m_acks = m_pipe[1];
      m_err  = 0;
      if (!m_busy) begin
        if (valid_i && !m_acks) begin
          m_busy = 1; m_req = 1; m_data = data_i; m_wait = 0;
        end
      end else if (m_req) begin
        if (m_acks) begin
          m_req = 0; m_wait = 0;
        end else if (TO_EN && m_wait + 1 >= TIMEOUT) begin
          m_req = 0; m_err = 1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end else begin
        if (!m_acks) begin
          m_busy = 0; m_wait = 0;
        end else if (TO_EN && m_wait + 1 >= TIMEOUT) begin
          m_busy = 0; m_err = 1; m_wait = 0;
        end else begin
          m_wait++;
        end
      end
      m_pipe = {m_pipe[0], ack_i};
    end
  end

  // ---------------- compare / monitor process ----------------
  logic [WIDTH+3:0] exp_v, act_v;
  logic             req_prev = 1'b0;
  logic [WIDTH-1:0] data_prev;
  int               req_rises = 0;
  int               err_pulses = 0;
  logic [WIDTH-1:0] cap_q[$];

  initial forever begin
    @(negedge clk);
    exp_v = {!m_busy && !m_pipe[1], m_req, m_busy, m_err, m_data};
    act_v = {ready_o, req_o, busy_o, err_o, data_o};
    chk("cycle{ready,req,busy,err,data}", act_v, exp_v);
    if (req_o === 1'b1 && req_prev === 1'b1) begin
      chk("data_stable_while_req", data_o, data_prev);
    end
    if (req_o === 1'b1 && req_prev !== 1'b1) begin
      req_rises++;
      cap_q.push_back(data_o);
    end
    if (err_o === 1'b1) err_pulses++;
    req_prev  = req_o;
    data_prev = data_o;
  end

  // ---------------- stimulus ----------------
  bit   follow = 0;
  bit   follow_dly = 0;
  logic req_d1 = 1'b0;

  // Advance one clock; the remote side optionally mirrors req onto ack.
  task automatic tick();
    @(posedge clk);
    #1;
    if (follow) begin
      if (follow_dly) ack_i = req_d1;
      else            ack_i = req_o;
    end
    req_d1 = req_o;
  endtask

  logic req_hist[0:15];
  logic rdy_hist[0:15];
  logic err_hist[0:15];
  int   r0, n, k, lowcnt, viol;
  bit   acc;
  logic [WIDTH-1:0] d0;

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; valid_i = 1'b0; data_i = '0; ack_i = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", req_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", ready_o, 1);

    // Minimum round trip with immediate ack mirroring.
    follow = 1; follow_dly = 0;
    valid_i = 1'b1; data_i = 8'h3C;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) valid_i = 1'b0;
      req_hist[i] = req_o;
      rdy_hist[i] = ready_o;
    end
    chk("rt_req_n1", req_hist[1], 1);
    chk("rt_req_n3", req_hist[3], 1);
    chk("rt_req_n4", req_hist[4], 0);
    chk("rt_ready_n6", rdy_hist[6], 0);
    chk("rt_ready_n7", rdy_hist[7], 1);
    chk("rt_data", data_o, 8'h3C);

    // Single transfer, ack follows req one cycle late.
    follow_dly = 1;
    r0 = req_rises;
    valid_i = 1'b1; data_i = 8'hA5;
    tick();
    valid_i = 1'b0;
    k = 1;
    while (k < 30 && !ready_o) begin
      tick();
      k++;
    end
    chk("a5_ready_back", ready_o, 1);
    chk("a5_ready_not_early", k >= 7, 1);
    chk("a5_data", data_o, 8'hA5);
    chk("a5_one_req_pulse", req_rises - r0, 1);
    repeat (3) tick();

    // Continuous valid with incrementing data: four accepted words.
    follow_dly = 0;
    r0 = req_rises;
    cap_q.delete();
    data_i = 8'h00; valid_i = 1'b1; n = 0;
    for (int i = 0; i < 80 && n < 4; i++) begin
      acc = ready_o && valid_i;
      tick();
      if (acc) begin
        n++;
        data_i = data_i + 8'h01;
        if (n == 4) valid_i = 1'b0;
      end
    end
    valid_i = 1'b0;
    for (int i = 0; i < 20 && !ready_o; i++) tick();
    chk("b2b_handshakes", req_rises - r0, 4);
    for (int i = 0; i < 4; i++) begin
      chk("b2b_data_seq", (cap_q.size() > i) ? cap_q[i] : 8'hXX, i);
    end
    chk("b2b_ready_back", ready_o, 1);

    // Reset during WAIT_HI with ack held high; stale ack then blocks accept.
    follow = 0; ack_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h5A;
    tick();
    valid_i = 1'b0;
    tick();
    ack_i = 1'b1;
    tick();
    chk("midrst_pre_req", req_o, 1);
    rst = 1'b1;
    #1;
    chk("midrst_req", req_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_busy", busy_o, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("stale_ack_ready_lo", ready_o, 0);
    valid_i = 1'b1; ack_i = 1'b0;
    tick();
    chk("stale_ack_ready_lo2", ready_o, 0);
    chk("stale_ack_no_req", req_o, 0);
    tick();
    valid_i = 1'b0;
    chk("stale_ack_ready_hi", ready_o, 1);
    chk("stale_ack_no_req2", req_o, 0);
    tick();
    chk("stale_ack_no_req3", req_o, 0);

    // One-cycle ack glitch in IDLE.
    r0 = req_rises; d0 = data_o; lowcnt = 0;
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    if (!ready_o) lowcnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!ready_o) lowcnt++;
    end
    chk("glitch_ready_low_1to2", (lowcnt >= 1) && (lowcnt <= 2), 1);
    chk("glitch_no_req", req_rises - r0, 0);
    chk("glitch_data", data_o, d0);

    // Stuck ack: timeout when compiled in, otherwise an indefinite wait.
    ack_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h77;
    tick();
    valid_i = 1'b0;
`ifdef UCDP_SYNC_HS_TIMEOUT_EN
    r0 = err_pulses;
    for (int i = 2; i <= 13; i++) begin
      tick();
      req_hist[i] = req_o;
      rdy_hist[i] = ready_o;
      err_hist[i] = err_o;
    end
    chk("to_err_n10", err_hist[10], 0);
    chk("to_req_n10", req_hist[10], 1);
    chk("to_err_n11", err_hist[11], 1);
    chk("to_req_n11", req_hist[11], 0);
    chk("to_err_n12", err_hist[12], 0);
    chk("to_ready_n12", rdy_hist[12], 1);
    chk("to_single_pulse", err_pulses - r0, 1);
    chk("to_data_kept", data_o, 8'h77);
`else
    viol = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (req_o !== 1'b1 || err_o !== 1'b0 || ready_o !== 1'b0) viol++;
    end
    chk("stuck_violations", viol, 0);
    chk("stuck_req", req_o, 1);
    chk("stuck_busy", busy_o, 1);
    chk("stuck_err_pulses", err_pulses, 0);
    chk("stuck_data", data_o, 8'h77);
`endif

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
